// File: rtl/vga_pixel_scheduler.sv
// rtl/vga_pixel_scheduler.sv - VGA raster counters, registered syncs/de and upstream pixel pull
module vga_pixel_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output logic                  underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Bounds carry one extra bit so a zero back porch cannot overflow the compare.
    localparam logic [HW:0]   H_ACT_B  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   H_SS_B   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SE_B   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW:0]   V_ACT_B  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   V_SS_B   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SE_B   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [HW-1:0]           r_h_cnt;
    logic [VW-1:0]           r_v_cnt;
    logic                    r_de;
    logic [DATA_WIDTH-1:0]   r_pix;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_frame_start;
    logic                    r_underflow;

    logic w_run;
    logic w_h_last;
    logic w_frame_end;
    logic w_act;
    logic w_hs_on;
    logic w_vs_on;
    logic w_run_entry;

    assign w_run       = (r_state == ST_RUN);
    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_frame_end = w_h_last && (r_v_cnt == V_LAST);
    assign w_act       = w_run && ({1'b0, r_h_cnt} < H_ACT_B) && ({1'b0, r_v_cnt} < V_ACT_B);
    assign w_hs_on     = w_run && ({1'b0, r_h_cnt} >= H_SS_B) && ({1'b0, r_h_cnt} < H_SE_B);
    assign w_vs_on     = w_run && ({1'b0, r_v_cnt} >= V_SS_B) && ({1'b0, r_v_cnt} < V_SE_B);
    assign w_run_entry = (r_state == ST_IDLE) && en;

    assign data_ready  = w_act;
    assign pix_out     = r_pix;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // en only matters in IDLE and at the last pixel of a frame; frames are never cut short.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_frame_end && !en) w_state_nxt = ST_STOP;
            ST_STOP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_run) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end else begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de          <= 1'b0;
            r_pix         <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_de          <= w_act;
            r_pix         <= (w_act && data_valid) ? data_in : '0;
            r_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_act && (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    // Sticky through STOP and IDLE so software can see it after the stream halts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_run_entry) begin
            r_underflow <= 1'b0;
        end else if (w_act && !data_valid) begin
            r_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// tb/tb_vga_pixel_scheduler.sv - directed bench for vga_pixel_scheduler on an 8x6 raster
module tb_vga_pixel_scheduler;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] pix_out;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       underflow;

    int n_chk;
    int n_pass;
    int cur_c;

    logic       e_de;
    logic [7:0] e_pix;
    logic       e_hs;
    logic       e_vs;
    logic       e_fs;
    logic       e_uf;

    vga_pixel_scheduler #(
        .DATA_WIDTH (8),
        .H_ACTIVE   (4),
        .H_FP       (1),
        .H_SYNC     (2),
        .H_BP       (1),
        .V_ACTIVE   (3),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .SYNC_POL   (1'b0)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .pix_out     (pix_out),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s c=%0d: got %0h expected %0h", tag, cur_c, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_expect();
        e_de  = 1'b0;
        e_pix = 8'h00;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_fs  = 1'b0;
    endtask

    task automatic check_all(input logic e_rdy);
        check("data_ready",  32'(data_ready),  32'(e_rdy));
        check("de",          32'(de),          32'(e_de));
        check("pix_out",     32'(pix_out),     32'(e_pix));
        check("hsync",       32'(hsync),       32'(e_hs));
        check("vsync",       32'(vsync),       32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("underflow",   32'(underflow),   32'(e_uf));
    endtask

    // Caller leaves the DUT in IDLE with en=1; position c counts clocks since RUN entry.
    task automatic run(input int ncyc, input int uf_c, input int en_off_c);
        int   run_end;
        int   h;
        int   v;
        logic run_now;
        logic act;
        run_end = (en_off_c < 0) ? (1 << 30) : ((en_off_c / 48) + 1) * 48;
        tick();
        set_reset_expect();
        e_uf = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            cur_c   = c;
            h       = c % 8;
            v       = (c / 8) % 6;
            run_now = (c < run_end);
            act     = run_now && (h < 4) && (v < 3);
            data_valid = (c != uf_c);
            data_in    = 8'(16 + (c / 48) * 12 + v * 4 + h);
            if (en_off_c >= 0) begin
                if (c == en_off_c || c == en_off_c + 6) en = 1'b0;
                else if (c == en_off_c + 4) en = 1'b1;
            end
            check_all(act);
            e_uf  = e_uf | (act && !data_valid);
            e_de  = act;
            e_pix = (act && data_valid) ? data_in : 8'h00;
            e_hs  = !(run_now && h >= 5 && h <= 6);
            e_vs  = !(run_now && v == 4);
            e_fs  = act && h == 0 && v == 0;
            if (c < ncyc - 1) tick();
        end
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        cur_c      = -1;
        rst_n      = 1'b0;
        en         = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        e_uf       = 1'b0;
        set_reset_expect();

        repeat (3) tick();
        check_all(1'b0);

        rst_n = 1'b1;
        data_valid = 1'b1;
        tick();
        tick();
        check_all(1'b0);

        // Frames 0..2: underflow at line 1 pixel 2 of frame 1, en dropped in frame 2.
        en = 1'b1;
        run(152, 58, 106);
        check("uf_sticky_idle", 32'(underflow), 32'd1);

        en = 1'b1;
        run(20, -1, -1);

        // Last sample sits at h=3, v=2: reset lands mid-line.
        rst_n = 1'b0;
        #1;
        cur_c = -2;
        set_reset_expect();
        e_uf = 1'b0;
        check_all(1'b0);
        tick();
        tick();
        check_all(1'b0);
        rst_n = 1'b1;
        run(50, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
